overdrive_seq: RTL and testbench

OVERDRIVE_SEQ -- requirements
Module: overdrive_seq

---
 rtl/overdrive_seq.sv | 84 ++++++++
 tb/tb_overdrive_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/overdrive_seq.sv
// overdrive_seq: sequential soft-clip overdrive y = (3x + x^3) / 4 with hard clamp at |x| >= THRESH.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    sample handshake, in_data signed Q(BITS_PER_LEVEL) sample
//   out_valid/out_ready  result handshake, out_data signed Q(BITS_PER_LEVEL) result
//   busy                 high whenever the FSM is not in IDLE
//   clip_count           16-bit saturating clamp counter, present only with OVERDRIVE_SEQ_CLIP_COUNT_EN
module fixed_multiply #(
  parameter int W    = 32,
  parameter int FRAC = 12
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);
  logic signed [2*W-1:0] w_full;
  assign w_full = a * b;
  assign p = W'(w_full >>> FRAC);
endmodule

module overdrive_seq #(
  parameter int BITS_PER_LEVEL = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_data,
  output logic               busy
`ifdef OVERDRIVE_SEQ_CLIP_COUNT_EN
  ,
  output logic        [15:0] clip_count
`endif
);
  localparam logic signed [31:0] THRESH = 32'sd2 <<< BITS_PER_LEVEL;
  localparam logic signed [31:0] HALF   = THRESH >>> 1;
  typedef enum logic [1:0] {IDLE, SQ, CU, DONE} state_t;
  state_t r_state, w_next;
  logic signed [31:0] r_x, r_sq, w_a, w_prod, w_res, w_out;
  logic w_clip;
  // One shared multiplier: x*x in SQ, x^2*x in CU.
  assign w_a = (r_state == SQ) ? r_x : r_sq;
  fixed_multiply #(.W(32), .FRAC(BITS_PER_LEVEL)) u_mul (.a(w_a), .b(r_x), .p(w_prod));
  assign w_res  = (r_x + r_x + r_x + w_prod) >>> 2;
  assign w_clip = (!r_x[31] && r_x >= THRESH) || (r_x[31] && r_x <= -THRESH);
  assign w_out  = !w_clip ? w_res : (r_x[31] ? -HALF : HALF);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next    = r_state;
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
    case (r_state)
      IDLE:    w_next = in_valid ? SQ : IDLE;
      SQ:      w_next = CU;
      CU:      w_next = DONE;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_x      <= '0;
      r_sq     <= '0;
      out_data <= '0;
    end else begin
      if (in_valid && in_ready) r_x <= in_data;
      if (r_state == SQ) r_sq <= w_prod;
      if (r_state == CU) out_data <= w_out;
    end
`ifdef OVERDRIVE_SEQ_CLIP_COUNT_EN
  logic [15:0] r_clip_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_clip_count <= '0;
    else if (r_state == CU && w_clip && r_clip_count != 16'hFFFF) r_clip_count <= r_clip_count + 16'd1;
  assign clip_count = r_clip_count;
`else
`endif
endmodule

// File: tb/tb_overdrive_seq.sv
// tb_overdrive_seq: table, corner-case and randomized checks of overdrive_seq against a plain arithmetic model.
module tb_overdrive_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic signed [31:0] in_data = '0, out_data;
`ifdef OVERDRIVE_SEQ_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif
  int checks = 0, errors = 0, clip_m = 0;
  overdrive_seq #(.BITS_PER_LEVEL(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef OVERDRIVE_SEQ_CLIP_COUNT_EN
    , .clip_count(clip_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] x; logic [31:0] y; } vec_t;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  function automatic bit is_clip(input int x);
    return x >= 8192 || x <= -8192;
  endfunction
  function automatic int model(input int x);
    longint sq, cu;
    int s32, c32;
    if (x >= 8192) return 4096;
    if (x <= -8192) return -4096;
    sq = (longint'(x) * longint'(x)) >>> 12;
    s32 = sq[31:0];
    cu = (longint'(s32) * longint'(x)) >>> 12;
    c32 = cu[31:0];
    return (3 * x + c32) >>> 2;
  endfunction
  task automatic run_one(input logic [31:0] x, output logic [31:0] got, output int lat);
    in_valid = 1'b1;
    in_data = x;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    got = out_data;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl[8];
    logic [31:0] got;
    int lat;
    tbl[0] = '{32'd4096, 32'd4096};
    tbl[1] = '{32'd2048, 32'd1664};
    tbl[2] = '{32'd0, 32'd0};
    tbl[3] = '{-32'sd4096, 32'hFFFFF000};
    tbl[4] = '{32'd8192, 32'd4096};
    tbl[5] = '{-32'sd8192, 32'hFFFFF000};
    tbl[6] = '{32'd8191, 32'd14332};
    tbl[7] = '{-32'sd8191, -32'sd14333};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      run_one(tbl[i].x, got, lat);
      chk($sformatf("tbl%0d_lat", i), lat, 2);
      chk($sformatf("tbl%0d_data", i), got, tbl[i].y);
      if (is_clip(tbl[i].x)) clip_m++;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_one_cycle", i), 32'(out_valid), 0);
    end
`ifdef OVERDRIVE_SEQ_CLIP_COUNT_EN
    chk("clip_count_tbl", 32'(clip_count), 2);
`endif
    in_valid = 1'b1;
    in_data = 2048;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_valid0", 32'(out_valid), 1);
    chk("stall_data0", out_data, 1664);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      in_data = 8192;
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", out_data, 1664);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", 32'(in_ready), 1);
    chk("release_busy", 32'(busy), 0);
    in_valid = 1'b0;
    in_data = 4096;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("cu_busy", 32'(busy), 1);
    chk("cu_out_valid", 32'(out_valid), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", 32'(in_ready), 1);
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_out_data", out_data, 0);
    clip_m = 0;
`ifdef OVERDRIVE_SEQ_CLIP_COUNT_EN
    chk("async_rst_clip", 32'(clip_count), 0);
`endif
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("no_stale", 32'(out_valid), 0);
    end
    run_one(2048, got, lat);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_data", got, 1664);
    @(posedge clk); #1;
    begin
      localparam int N = 40;
      int vals[N];
      int q_exp[$];
      int idx = 0, nres = 0, last_acc = -1;
      bit acc;
      for (int i = 0; i < N; i++)
        vals[i] = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 20000)) - 10000;
      in_valid = 1'b1;
      in_data = vals[0];
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 4 * N + 20 && nres < N; cyc++) begin
        acc = in_ready && in_valid;
        @(posedge clk); #1;
        if (acc) begin
          if (last_acc >= 0) chk("b2b_gap", cyc - last_acc, 4);
          last_acc = cyc;
          q_exp.push_back(model(vals[idx]));
          if (is_clip(vals[idx])) clip_m++;
          idx++;
          if (idx < N) in_data = vals[idx];
          else in_valid = 1'b0;
        end
        if (out_valid) begin
          if (q_exp.size() == 0) chk("b2b_unexpected_out", 32'(out_valid), 0);
          else chk("b2b_data", out_data, q_exp.pop_front());
          nres++;
        end
      end
      in_valid = 1'b0;
      chk("b2b_count", nres, N);
    end
`ifdef OVERDRIVE_SEQ_CLIP_COUNT_EN
    chk("clip_count_rand", 32'(clip_count), clip_m);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
